// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, flag bit positions and FSM encoding shared by the ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int FLAG_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
    localparam logic [OP_W-1:0] OP_LSH  = 5'd7;
    localparam logic [OP_W-1:0] OP_RSH  = 5'd8;
    localparam logic [OP_W-1:0] OP_ARSH = 5'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd10;
    localparam logic [OP_W-1:0] OP_ADDC = 5'd11;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb
// Brief    : Single-cycle arithmetic, compare and logic results plus flags.
// Revision : 1.0
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
    output logic             wr_res_o,
    output logic             wr_cf_o,
    output logic             wr_lzn_o,
    output logic             c_o,
    output logic             f_o,
    output logic             l_o,
    output logic             z_o,
    output logic             n_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // One adder serves ADD, ADDC and SUB; SUB feeds the inverted operand.
    always_comb begin
        w_b_eff   = (op_i == OP_SUB) ? ~b_i : b_i;
        w_cin_eff = 1'b0;
        if (op_i == OP_SUB) begin
            w_cin_eff = 1'b1;
        end else if (op_i == OP_ADDC) begin
            w_cin_eff = cin_i;
        end
        w_sum = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
    end

    assign c_o = w_sum[WIDTH];
    assign f_o = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
    assign l_o = (a_i < b_i);
    assign z_o = (a_i == b_i);
    assign n_o = ($signed(a_i) < $signed(b_i));

    always_comb begin
        res_o    = '0;
        wr_res_o = 1'b1;
        wr_cf_o  = 1'b0;
        wr_lzn_o = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_ADDC: begin
                res_o    = w_sum[WIDTH-1:0];
                wr_cf_o  = 1'b1;
                wr_lzn_o = 1'b1;
            end
            OP_CMP: begin
                wr_res_o = 1'b0;
                wr_lzn_o = 1'b1;
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NOT:  res_o = ~b_i;
            // Only reached here with a zero shift amount.
            OP_LSH, OP_RSH, OP_ARSH: res_o = a_i;
            default: res_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Sequential ALU: handshake FSM, bit-serial shifter, shift-add MUL.
// Revision : 1.0
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  rdest,
    input  logic [WIDTH-1:0]  rsrc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [WIDTH-1:0]    work_q, work_d;
    logic [WIDTH-1:0]    aux_q, aux_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic [SHW-1:0]      w_amt;
    logic [WIDTH-1:0]    w_shift;
    logic [WIDTH-1:0]    w_acc;
    logic [WIDTH-1:0]    w_alu_res;
    logic                w_wr_res, w_wr_cf, w_wr_lzn;
    logic                w_c, w_f, w_l, w_z, w_n;

    assign w_amt = rsrc[SHW-1:0];

    alu_comb #(
        .WIDTH    (WIDTH)
    ) u_alu_comb (
        .op_i     (op),
        .a_i      (rdest),
        .b_i      (rsrc),
        .cin_i    (flags_q[FLAG_C]),
        .res_o    (w_alu_res),
        .wr_res_o (w_wr_res),
        .wr_cf_o  (w_wr_cf),
        .wr_lzn_o (w_wr_lzn),
        .c_o      (w_c),
        .f_o      (w_f),
        .l_o      (w_l),
        .z_o      (w_z),
        .n_o      (w_n)
    );

    // work_q holds the value being shifted, or the multiplicand for MUL.
    always_comb begin
        case (op_q)
            OP_LSH:  w_shift = {work_q[WIDTH-2:0], 1'b0};
            OP_RSH:  w_shift = {1'b0, work_q[WIDTH-1:1]};
            default: w_shift = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
        w_acc = acc_q + (aux_q[0] ? work_q : {WIDTH{1'b0}});
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        aux_d    = aux_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (is_shift(op) && (w_amt != '0)) begin
                        work_d  = rdest;
                        cnt_d   = {1'b0, w_amt};
                        state_d = ST_EXEC;
                    end else if (op == OP_MUL) begin
                        work_d  = rdest;
                        aux_d   = rsrc;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_EXEC;
                    end else begin
                        if (w_wr_res) begin
                            result_d = w_alu_res;
                        end
                        if (w_wr_cf) begin
                            flags_d[FLAG_C] = w_c;
                            flags_d[FLAG_F] = w_f;
                        end
                        if (w_wr_lzn) begin
                            flags_d[FLAG_L] = w_l;
                            flags_d[FLAG_Z] = w_z;
                            flags_d[FLAG_N] = w_n;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                    aux_d  = {1'b0, aux_q[WIDTH-1:1]};
                    acc_d  = w_acc;
                end else begin
                    work_d = w_shift;
                end
                if (cnt_q == CW'(1)) begin
                    result_d = (op_q == OP_MUL) ? w_acc : w_shift;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            work_q   <= '0;
            aux_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            aux_q    <= aux_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq (WIDTH=16) with a reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [15:0] rdest;
    logic [15:0] rsrc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rdest     (rdest),
        .rsrc      (rsrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [15:0] res;
        logic [4:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    bit          seen;
    int          cyc;
    int          n_chk;
    int          n_fail;
    int          rdy_mode;
    logic [15:0] m_res;
    logic [4:0]  m_fl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic predict(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                           output exp_t e);
        longint ua, ub, sa, sb, s, so;
        int     k;
        bit     c, f, l, z, n;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        k  = int'(b[3:0]);
        c  = m_fl[0]; l = m_fl[1]; f = m_fl[2]; z = m_fl[3]; n = m_fl[4];
        e.lat = 1;
        if (o == 5'd0 || o == 5'd1 || o == 5'd11 || o == 5'd2) begin
            if (o == 5'd1) begin
                s  = ua + (ub ^ 64'hFFFF) + 1;
                so = sa - sb;
            end else begin
                s  = ua + ub + ((o == 5'd11) ? longint'(m_fl[0]) : 0);
                so = sa + sb + ((o == 5'd11) ? longint'(m_fl[0]) : 0);
            end
            if (o != 5'd2) begin
                m_res = s[15:0];
                c = s[16];
                f = (so > 32767) || (so < -32768);
            end
            l = (ua < ub);
            z = (ua == ub);
            n = (sa < sb);
        end else begin
            case (o)
                5'd3:  m_res = a & b;
                5'd4:  m_res = a | b;
                5'd5:  m_res = a ^ b;
                5'd6:  m_res = ~b;
                5'd7:  begin s = ua << k;  m_res = s[15:0]; e.lat = k + 1; end
                5'd8:  begin s = ua >> k;  m_res = s[15:0]; e.lat = k + 1; end
                5'd9:  begin s = sa >>> k; m_res = s[15:0]; e.lat = k + 1; end
                5'd10: begin s = ua * ub;  m_res = s[15:0]; e.lat = 17; end
                default: m_res = 16'h0000;
            endcase
        end
        m_fl  = {n, z, f, l, c};
        e.res = m_res;
        e.fl  = m_fl;
    endtask

    task automatic issue(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        op       = o;
        rdest    = a;
        rsrc     = b;
        predict(o, a, b, e);
        e.acc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 5'($urandom);
        rdest    = 16'($urandom);
        rsrc     = 16'($urandom);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("result", 64'(result), 64'(cur.res));
                    chk("flags", 64'(flags), 64'(cur.fl));
                    chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                end
                seen = 1'b1;
            end else begin
                chk("hold_result", 64'(result), 64'(cur.res));
                chk("hold_flags", 64'(flags), 64'(cur.fl));
            end
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) seen = 1'b0;
        end
    end

    initial begin
        int w;
        cyc = 0; n_chk = 0; n_fail = 0; rdy_mode = 0; seen = 1'b0;
        m_res = '0; m_fl = '0;
        reset = 1'b1; in_valid = 1'b0; op = '0; rdest = '0; rsrc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);

        issue(5'd0, 16'hFFFF, 16'h0001);
        issue(5'd1, 16'h8000, 16'h0001);
        issue(5'd11, 16'h0001, 16'h0001);
        issue(5'd7, 16'h0001, 16'h0004);
        issue(5'd9, 16'h8000, 16'h000F);
        issue(5'd8, 16'h1234, 16'h0000);
        issue(5'd10, 16'h0012, 16'h0034);
        issue(5'd2, 16'h0005, 16'h0009);
        issue(5'd6, 16'h0000, 16'h00F0);
        issue(5'd20, 16'h1234, 16'h5678);

        // Result held in DONE while the consumer stalls; requests ignored.
        rdy_mode = 2;
        @(posedge clk);
        issue(5'd5, 16'hA5A5, 16'h0FF0);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            in_valid = 1'b1;
            op       = 5'd0;
            rdest    = 16'($urandom);
            rsrc     = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_mode = 0;

        // Reset lands in the fifth MUL EXEC cycle, with competing handshakes.
        issue(5'd10, 16'h1234, 16'h00FF);
        repeat (4) @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        op       = 5'd0;
        sb_q.delete();
        m_res = '0;
        m_fl  = '0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_flags", 64'(flags), 64'd0);

        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            logic [4:0] ro;
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(12, 31))
                                             : 5'($urandom_range(0, 11));
            issue(ro, 16'($urandom), 16'($urandom));
        end

        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
